// File: rtl/vm_change_dispenser_if.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser_if
//   Bundles the request, refill, coin-eject and status signals of the change
//   dispenser so that one interface port carries the whole block boundary.
//
//   master : vending controller / test side (drives request and refill)
//   slave  : the dispenser itself (drives pulses, status and inventory)
//
//   Signals
//     req_valid, req_amount      change request from the controller
//     req_ready                  dispenser can accept (IDLE only)
//     refill_valid/ten/five      inventory refill, applied while IDLE
//     coin10, coin5              one-cycle hopper eject pulses
//     done, err, err_code        completion / rejection status
//     busy                       dispenser not IDLE
//     ten_count, five_count      live coin inventory
//     paid_total                 only with VM_DISP_STATS_EN defined
// ---------------------------------------------------------------------------
interface vm_change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic             refill_valid;
    logic [CNT_W-1:0] refill_ten;
    logic [CNT_W-1:0] refill_five;
    logic             coin10;
    logic             coin5;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic             busy;
    logic [CNT_W-1:0] ten_count;
    logic [CNT_W-1:0] five_count;
`ifdef VM_DISP_STATS_EN
    logic [15:0]      paid_total;
`endif

    modport master (
        output req_valid, req_amount, refill_valid, refill_ten, refill_five,
        input  req_ready, coin10, coin5, done, err, err_code, busy,
               ten_count, five_count
`ifdef VM_DISP_STATS_EN
        , input paid_total
`endif
    );

    modport slave (
        input  req_valid, req_amount, refill_valid, refill_ten, refill_five,
        output req_ready, coin10, coin5, done, err, err_code, busy,
               ten_count, five_count
`ifdef VM_DISP_STATS_EN
        , output paid_total
`endif
    );
endinterface

// File: rtl/vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser
//   Payout end of the vending machine coin path. Accepts a change amount in
//   rupees, pays it with ten-rupee coins first and five-rupee coins after,
//   one eject pulse per coin followed by PULSE_GAP idle cycles. Requests that
//   are not a multiple of 5 or cannot be paid exactly from the on-board
//   inventory are rejected without touching the inventory.
//
//   Ports
//     clk   rising-edge system clock
//     rst   asynchronous, active-high reset (aborts any payout)
//     bus   vm_change_dispenser_if.slave: request, refill, coin pulses,
//           done/err/err_code, busy, ten_count/five_count
//
//   Optional build macro
//     VM_DISP_STATS_EN : adds bus.paid_total, a saturating 16-bit running
//                        total of rupees ejected (reset 0).
// ---------------------------------------------------------------------------
module vm_change_dispenser #(
    parameter int AMT_W     = 8,
    parameter int CNT_W     = 8,
    parameter int PULSE_GAP = 2,
    parameter int INIT_TEN  = 16,
    parameter int INIT_FIVE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    vm_change_dispenser_if.slave bus
);

    // Common width for the CHECK arithmetic so amount and counts compare
    // zero-extended.
    localparam int WW    = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;
    localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_DISPENSE = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_FIN      = 3'd4;

    logic [2:0]       state;
    logic [AMT_W-1:0] amount;
    logic [AMT_W-1:0] tens_left;
    logic [AMT_W-1:0] fives_left;
    logic [GAP_W-1:0] gap_cnt;
    logic             fin_err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] ten_count;
    logic [CNT_W-1:0] five_count;

    // CHECK-stage arithmetic
    logic [WW-1:0] amt_w;
    logic [WW-1:0] q10_w;
    logic [WW-1:0] tens_w;
    logic [WW-1:0] rem_w;
    logic [WW-1:0] fives_w;
    logic          mult5;
    logic          short_five;

    // Refill saturation
    logic [CNT_W:0]   ten_sum;
    logic [CNT_W:0]   five_sum;
    logic [CNT_W-1:0] ten_refilled;
    logic [CNT_W-1:0] five_refilled;

    logic coin10_q;
    logic coin5_q;

    always_comb begin
        amt_w      = WW'(amount);
        q10_w      = amt_w / WW'(10);
        tens_w     = (q10_w < WW'(ten_count)) ? q10_w : WW'(ten_count);
        // tens_w*10 never exceeds the amount, so this cannot underflow.
        rem_w      = amt_w - (tens_w * WW'(10));
        fives_w    = rem_w / WW'(5);
        mult5      = ((amt_w % WW'(5)) == '0);
        short_five = (fives_w > WW'(five_count));
    end

    always_comb begin
        ten_sum       = {1'b0, ten_count} + {1'b0, bus.refill_ten};
        five_sum      = {1'b0, five_count} + {1'b0, bus.refill_five};
        ten_refilled  = ten_sum[CNT_W]  ? '1 : ten_sum[CNT_W-1:0];
        five_refilled = five_sum[CNT_W] ? '1 : five_sum[CNT_W-1:0];
    end

    // Ten-rupee coins are paid while any remain, so the coin type is
    // decided purely by tens_left in the DISPENSE cycle.
    assign coin10_q = (state == S_DISPENSE) && (tens_left != '0);
    assign coin5_q  = (state == S_DISPENSE) && (tens_left == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            amount     <= '0;
            tens_left  <= '0;
            fives_left <= '0;
            gap_cnt    <= '0;
            fin_err    <= 1'b0;
            err_code   <= '0;
            ten_count  <= CNT_W'(INIT_TEN);
            five_count <= CNT_W'(INIT_FIVE);
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.refill_valid) begin
                        ten_count  <= ten_refilled;
                        five_count <= five_refilled;
                    end
                    if (bus.req_valid) begin
                        amount   <= bus.req_amount;
                        err_code <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!mult5) begin
                        err_code <= 2'b01;
                        fin_err  <= 1'b1;
                        state    <= S_FIN;
                    end else if (short_five) begin
                        err_code <= 2'b10;
                        fin_err  <= 1'b1;
                        state    <= S_FIN;
                    end else if ((tens_w == '0) && (fives_w == '0)) begin
                        fin_err <= 1'b0;
                        state   <= S_FIN;
                    end else begin
                        tens_left  <= AMT_W'(tens_w);
                        fives_left <= AMT_W'(fives_w);
                        fin_err    <= 1'b0;
                        state      <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (tens_left != '0) begin
                        tens_left <= tens_left - 1'b1;
                        ten_count <= ten_count - 1'b1;
                    end else begin
                        fives_left <= fives_left - 1'b1;
                        five_count <= five_count - 1'b1;
                    end
                    gap_cnt <= GAP_W'(PULSE_GAP - 1);
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if ((tens_left == '0) && (fives_left == '0)) begin
                        state <= S_FIN;
                    end else begin
                        state <= S_DISPENSE;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VM_DISP_STATS_EN
    logic [15:0] paid_total;
    logic [15:0] paid_inc;

    always_comb begin
        paid_inc = coin10_q ? 16'd10 : (coin5_q ? 16'd5 : 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paid_total <= '0;
        end else if (paid_total > (16'hFFFF - paid_inc)) begin
            paid_total <= '1;
        end else begin
            paid_total <= paid_total + paid_inc;
        end
    end

    assign bus.paid_total = paid_total;
`endif

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.coin10     = coin10_q;
    assign bus.coin5      = coin5_q;
    assign bus.done       = (state == S_FIN) && !fin_err;
    assign bus.err        = (state == S_FIN) && fin_err;
    assign bus.err_code   = err_code;
    assign bus.ten_count  = ten_count;
    assign bus.five_count = five_count;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vm_change_dispenser
//   Self-checking bench for vm_change_dispenser: a table of directed
//   requests with hand-derived expectations, a reset-during-payout sequence,
//   and randomized requests checked against an arithmetic inventory model.
// ---------------------------------------------------------------------------
module tb_vm_change_dispenser;

    localparam int AMT_W     = 8;
    localparam int CNT_W     = 8;
    localparam int PULSE_GAP = 2;
    localparam int INIT_TEN  = 16;
    localparam int INIT_FIVE = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // Reference inventory
    int m_ten;
    int m_five;

    vm_change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    vm_change_dispenser #(
        .AMT_W    (AMT_W),
        .CNT_W    (CNT_W),
        .PULSE_GAP(PULSE_GAP),
        .INIT_TEN (INIT_TEN),
        .INIT_FIVE(INIT_FIVE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "time limit");
    end

    typedef struct {
        bit do_rst;
        int amt;
        bit rf;
        int rt;
        int r5;
        bit busy_rf;
        int code;
        int tens;
        int fives;
        int pre_t;
        int pre_f;
        int post_t;
        int post_f;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_amount   = '0;
        bus.refill_valid = 1'b0;
        bus.refill_ten   = '0;
        bus.refill_five  = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        m_ten  = INIT_TEN;
        m_five = INIT_FIVE;
        @(negedge clk);
    endtask

    // Spec rules expressed directly on integers.
    task automatic model_req(input int amt, input bit rf, input int rt, input int r5,
                             output int code, output int tens, output int fives,
                             output int pre_t, output int pre_f,
                             output int post_t, output int post_f);
        if (rf) begin
            m_ten  = (m_ten + rt > CNT_MAX) ? CNT_MAX : m_ten + rt;
            m_five = (m_five + r5 > CNT_MAX) ? CNT_MAX : m_five + r5;
        end
        pre_t = m_ten;
        pre_f = m_five;
        code  = 0;
        tens  = 0;
        fives = 0;
        if (amt % 5 != 0) begin
            code = 1;
        end else begin
            tens  = (amt / 10 < m_ten) ? amt / 10 : m_ten;
            fives = (amt - 10 * tens) / 5;
            if (fives > m_five) begin
                code  = 2;
                tens  = 0;
                fives = 0;
            end
        end
        m_ten  = m_ten - tens;
        m_five = m_five - fives;
        post_t = m_ten;
        post_f = m_five;
    endtask

    // Issue one request at cycle T (the negedge sampled here) and follow it
    // cycle by cycle to one cycle past the expected done/err pulse.
    task automatic run_req(input string tag, input int amt, input bit rf,
                           input int rt, input int r5, input bit busy_rf,
                           input int code, input int tens, input int fives,
                           input int pre_t, input int pre_f,
                           input int post_t, input int post_f);
        int n;
        int fin_off;
        int sched_err;
        int c10;
        int c5;
        int k;
        bit exp10;
        bit exp5;
        n         = tens + fives;
        fin_off   = 2 + n * (PULSE_GAP + 1);
        sched_err = 0;
        c10       = 0;
        c5        = 0;
        @(negedge clk);
        chk({tag, " req_ready_before"}, int'(bus.req_ready), 1);
        bus.req_valid    = 1'b1;
        bus.req_amount   = AMT_W'(amt);
        bus.refill_valid = rf;
        bus.refill_ten   = CNT_W'(rt);
        bus.refill_five  = CNT_W'(r5);
        for (int off = 1; off <= fin_off + 1; off++) begin
            @(negedge clk);
            if (off == 1) begin
                bus.req_valid    = 1'b0;
                bus.refill_valid = 1'b0;
                chk({tag, " err_code_cleared"}, int'(bus.err_code), 0);
                chk({tag, " ten_count_at_check"}, int'(bus.ten_count), pre_t);
                chk({tag, " five_count_at_check"}, int'(bus.five_count), pre_f);
            end
            if (busy_rf && off == 3) begin
                bus.refill_valid = 1'b1;
                bus.refill_ten   = CNT_W'(200);
                bus.refill_five  = CNT_W'(200);
            end
            if (busy_rf && off == 4) bus.refill_valid = 1'b0;
            k     = off - 2;
            exp10 = 1'b0;
            exp5  = 1'b0;
            if (k >= 0 && (k % (PULSE_GAP + 1)) == 0 && (k / (PULSE_GAP + 1)) < n) begin
                exp10 = (k / (PULSE_GAP + 1)) < tens;
                exp5  = !exp10;
            end
            if (bus.coin10 !== exp10) sched_err++;
            if (bus.coin5 !== exp5) sched_err++;
            if (bus.done !== (off == fin_off && code == 0)) sched_err++;
            if (bus.err !== (off == fin_off && code != 0)) sched_err++;
            if (bus.busy !== (off <= fin_off)) sched_err++;
            if (bus.coin10 === 1'b1) c10++;
            if (bus.coin5 === 1'b1) c5++;
        end
        chk({tag, " cycle_schedule_errors"}, sched_err, 0);
        chk({tag, " coin10_pulses"}, c10, tens);
        chk({tag, " coin5_pulses"}, c5, fives);
        chk({tag, " err_code"}, int'(bus.err_code), code);
        chk({tag, " ten_count"}, int'(bus.ten_count), post_t);
        chk({tag, " five_count"}, int'(bus.five_count), post_f);
        chk({tag, " req_ready_after"}, int'(bus.req_ready), 1);
    endtask

    initial begin
        //            rst amt  rf rt  r5   brf code tens fv  preT preF postT postF
        vecs[0] = '{1'b1,   7, 1'b0, 0,   0, 1'b0, 1,  0,  0, 16,  16, 16,  16};
        vecs[1] = '{1'b0,   0, 1'b0, 0,   0, 1'b0, 0,  0,  0, 16,  16, 16,  16};
        vecs[2] = '{1'b0,  25, 1'b0, 0,   0, 1'b0, 0,  2,  1, 16,  16, 14,  15};
        vecs[3] = '{1'b1, 160, 1'b0, 0,   0, 1'b0, 0, 16,  0, 16,  16,  0,  16};
        vecs[4] = '{1'b0,  20, 1'b0, 0,   0, 1'b0, 0,  0,  4,  0,  16,  0,  12};
        vecs[5] = '{1'b0, 100, 1'b0, 0,   0, 1'b0, 2,  0,  0,  0,  12,  0,  12};
        vecs[6] = '{1'b1,  15, 1'b1, 3, 250, 1'b1, 0,  1,  1, 19, 255, 18, 254};
        vecs[7] = '{1'b0, 255, 1'b0, 0,   0, 1'b0, 0, 18, 15, 18, 254,  0, 239};
        vecs[8] = '{1'b0,   5, 1'b0, 0,   0, 1'b0, 0,  0,  1,  0, 239,  0, 238};
        vecs[9] = '{1'b0,  12, 1'b0, 0,   0, 1'b0, 1,  0,  0,  0, 238,  0, 238};

        do_reset();
        chk("reset coin10", int'(bus.coin10), 0);
        chk("reset coin5", int'(bus.coin5), 0);
        chk("reset done_err", int'({bus.done, bus.err}), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset err_code", int'(bus.err_code), 0);
        chk("reset req_ready", int'(bus.req_ready), 1);
        chk("reset ten_count", int'(bus.ten_count), INIT_TEN);
        chk("reset five_count", int'(bus.five_count), INIT_FIVE);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].do_rst) do_reset();
            run_req(tag, vecs[i].amt, vecs[i].rf, vecs[i].rt, vecs[i].r5, vecs[i].busy_rf,
                    vecs[i].code, vecs[i].tens, vecs[i].fives,
                    vecs[i].pre_t, vecs[i].pre_f, vecs[i].post_t, vecs[i].post_f);
            if (vecs[i].code != 0) begin
                repeat (3) @(negedge clk);
                chk({tag, " err_code_held"}, int'(bus.err_code), vecs[i].code);
            end
        end

        // Reset during payout: req 50, reset in the cycle of the 2nd coin10
        begin
            int seen;
            int stray;
            bit hit;
            do_reset();
            seen = 0;
            hit  = 1'b0;
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_amount = AMT_W'(50);
            for (int c = 0; c < 40 && !hit; c++) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
                if (bus.coin10 === 1'b1) seen++;
                if (seen == 2) begin
                    hit = 1'b1;
                    rst = 1'b1;
                    #1;
                    chk("midrst coin10", int'(bus.coin10), 0);
                    chk("midrst coin5", int'(bus.coin5), 0);
                    chk("midrst done_err", int'({bus.done, bus.err}), 0);
                    chk("midrst busy", int'(bus.busy), 0);
                    chk("midrst req_ready", int'(bus.req_ready), 1);
                    chk("midrst ten_count", int'(bus.ten_count), 16);
                    chk("midrst five_count", int'(bus.five_count), 16);
                end
            end
            chk("midrst second_coin10_seen", int'(hit), 1);
            @(negedge clk);
            rst   = 1'b0;
            stray = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.coin10 !== 1'b0 || bus.coin5 !== 1'b0 || bus.done !== 1'b0 ||
                    bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) stray++;
            end
            chk("midrst quiet_after_reset", stray, 0);
        end

        // Randomized requests against the model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            int amt, rt, r5, code, tens, fives, pre_t, pre_f, post_t, post_f;
            bit rf;
            amt = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) amt = amt - (amt % 5);
            rf = ($urandom_range(0, 3) == 0);
            rt = int'($urandom_range(0, 40));
            r5 = int'($urandom_range(0, 40));
            model_req(amt, rf, rt, r5, code, tens, fives, pre_t, pre_f, post_t, post_f);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_req($sformatf("rnd%0d_amt%0d", r, amt), amt, rf, rt, r5, 1'b0,
                    code, tens, fives, pre_t, pre_f, post_t, post_f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
